// File: rtl/axi_line_master.sv
// axi_line_master: arbitrates two cache clients onto single-beat AXI-lite read/write transactions
module axi_line_master #(
  parameter logic [2:0] AXI_PROT = 3'b000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c0_req_valid,
  output logic         c0_req_ready,
  input  logic         c0_req_write,
  input  logic [63:0]  c0_req_addr,
  input  logic [127:0] c0_req_wdata,
  input  logic [15:0]  c0_req_wstrb,
  output logic         c0_rsp_valid,
  output logic [127:0] c0_rsp_rdata,
  output logic [1:0]   c0_rsp_resp,
  input  logic         c1_req_valid,
  output logic         c1_req_ready,
  input  logic         c1_req_write,
  input  logic [63:0]  c1_req_addr,
  input  logic [127:0] c1_req_wdata,
  input  logic [15:0]  c1_req_wstrb,
  output logic         c1_rsp_valid,
  output logic [127:0] c1_rsp_rdata,
  output logic [1:0]   c1_rsp_resp,
  input  logic         axi_readAddr_ready,
  output logic         axi_readAddr_valid,
  output logic [63:0]  axi_readAddr_bits_addr,
  output logic [2:0]   axi_readAddr_bits_prot,
  input  logic         axi_readData_valid,
  output logic         axi_readData_ready,
  input  logic [127:0] axi_readData_bits_data,
  input  logic [1:0]   axi_readData_bits_resp,
  input  logic         axi_writeAddr_ready,
  output logic         axi_writeAddr_valid,
  output logic [63:0]  axi_writeAddr_bits_addr,
  output logic [2:0]   axi_writeAddr_bits_prot,
  input  logic         axi_writeData_ready,
  output logic         axi_writeData_valid,
  output logic [127:0] axi_writeData_bits_data,
  output logic [15:0]  axi_writeData_bits_strb,
  input  logic         axi_writeResp_valid,
  output logic         axi_writeResp_ready,
  input  logic [1:0]   axi_writeResp_bits
);
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, RSP} state_t;
  state_t state;
  logic last_grant, grant, accept, sel_write;
  logic [63:0] addr;
  logic [127:0] wdata, rdata;
  logic [15:0] wstrb;
  logic [1:0] resp;
  always_comb begin
    grant = (c0_req_valid && c1_req_valid) ? !last_grant : c1_req_valid;
    accept = state == IDLE && (c0_req_valid || c1_req_valid);
    sel_write = grant ? c1_req_write : c0_req_write;
  end
  assign c0_req_ready = accept && !grant;
  assign c1_req_ready = accept && grant;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
      rdata <= '0;
      resp <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          last_grant <= grant;
          addr <= (grant ? c1_req_addr : c0_req_addr) & ~64'hF;
          wdata <= grant ? c1_req_wdata : c0_req_wdata;
          wstrb <= grant ? c1_req_wstrb : c0_req_wstrb;
          state <= sel_write ? AW : AR;
        end
        AR: if (axi_readAddr_ready) state <= R;
        R: if (axi_readData_valid) begin
          rdata <= axi_readData_bits_data;
          resp <= axi_readData_bits_resp;
          state <= RSP;
        end
        AW: if (axi_writeAddr_ready) state <= W;
        W: if (axi_writeData_ready) state <= B;
        B: if (axi_writeResp_valid) begin
          rdata <= '0;
          resp <= axi_writeResp_bits;
          state <= RSP;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Channel controls decode the registered state only, so no AXI input reaches an AXI output.
  assign axi_readAddr_valid = state == AR;
  assign axi_readData_ready = state == R;
  assign axi_writeAddr_valid = state == AW;
  assign axi_writeData_valid = state == W;
  assign axi_writeResp_ready = state == B;
  assign axi_readAddr_bits_addr = addr;
  assign axi_writeAddr_bits_addr = addr;
  assign axi_readAddr_bits_prot = AXI_PROT;
  assign axi_writeAddr_bits_prot = AXI_PROT;
  assign axi_writeData_bits_data = wdata;
  assign axi_writeData_bits_strb = wstrb;
  assign c0_rsp_valid = state == RSP && !last_grant;
  assign c1_rsp_valid = state == RSP && last_grant;
  assign c0_rsp_rdata = rdata;
  assign c1_rsp_rdata = rdata;
  assign c0_rsp_resp = resp;
  assign c1_rsp_resp = resp;
endmodule
